// File: rtl/rca_adder_arbiter.sv
// Round-robin sequencer that shares one external ripple-carry adder among N_REQ requesters.
// Latency: gnt 1 cycle after req is sampled in IDLE, done SETTLE cycles after gnt, SETTLE+2 cycles per operation.
// Backpressure: req is a level that is sampled only in IDLE; requesters stay pending until they are granted.
module rca_adder_arbiter #(
    parameter int WIDTH  = 64,
    parameter int N_REQ  = 4,
    parameter int SETTLE = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    input  logic [N_REQ-1:0]       cin,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic [WIDTH-1:0]       sum_out,
    output logic                   cout_out,
    output logic                   busy,
    output logic [WIDTH-1:0]       add_a,
    output logic [WIDTH-1:0]       add_b,
    output logic                   add_c0,
    input  logic [WIDTH-1:0]       add_s,
    input  logic                   add_c
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      win_q, win_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic [WIDTH-1:0]   add_a_q, add_a_d;
    logic [WIDTH-1:0]   add_b_q, add_b_d;
    logic               add_c0_q, add_c0_d;

    logic               found;
    logic [PW-1:0]      pick;
    int                 idx;

    // Round-robin search: first asserted request starting at ptr, wrapping modulo N_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = (int'(ptr_q) + i) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    // Next-state logic: grant and latch operands, count down the settle time, capture, then advance ptr.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        cnt_d    = cnt_q;
        gnt_d    = gnt_q;
        done_d   = done_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        add_a_d  = add_a_q;
        add_b_d  = add_b_q;
        add_c0_d = add_c0_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    win_d    = pick;
                    add_a_d  = a_in[pick*WIDTH +: WIDTH];
                    add_b_d  = b_in[pick*WIDTH +: WIDTH];
                    add_c0_d = cin[pick];
                    gnt_d    = N_REQ'(1) << pick;
                    cnt_d    = CW'(SETTLE);
                    state_d  = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q > CW'(1)) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // The carry chain has had SETTLE cycles of stable inputs; the result is valid now.
                    sum_d   = add_s;
                    cout_d  = add_c;
                    done_d  = N_REQ'(1) << win_q;
                    gnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_d  = '0;
                ptr_d   = (win_q == PW'(N_REQ - 1)) ? '0 : win_q + PW'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            win_q    <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            add_a_q  <= '0;
            add_b_q  <= '0;
            add_c0_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            add_a_q  <= add_a_d;
            add_b_q  <= add_b_d;
            add_c0_q <= add_c0_d;
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign sum_out  = sum_q;
    assign cout_out = cout_q;
    assign busy     = (state_q != S_IDLE);
    assign add_a    = add_a_q;
    assign add_b    = add_b_q;
    assign add_c0   = add_c0_q;

endmodule

// File: tb/tb_rca_adder_arbiter.sv
// Directed bench for rca_adder_arbiter with a behavioural shared adder on the add_* ports.
// Each operation is checked for grant order, grant-to-done latency, and the captured sum/carry.
// Ends with a mid-operation reset to confirm the in-flight operation is aborted.
module tb_rca_adder_arbiter;

    localparam int WIDTH  = 64;
    localparam int N_REQ  = 4;
    localparam int SETTLE = 2;

    logic                   clk;
    logic                   rst_n;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] a_in;
    logic [N_REQ*WIDTH-1:0] b_in;
    logic [N_REQ-1:0]       cin;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic [WIDTH-1:0]       sum_out;
    logic                   cout_out;
    logic                   busy;
    logic [WIDTH-1:0]       add_a;
    logic [WIDTH-1:0]       add_b;
    logic                   add_c0;
    logic [WIDTH-1:0]       add_s;
    logic                   add_c;

    int checks;
    int errors;
    int cyc;
    int last_gnt_cyc;

    rca_adder_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .SETTLE(SETTLE)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .cin      (cin),
        .gnt      (gnt),
        .done     (done),
        .sum_out  (sum_out),
        .cout_out (cout_out),
        .busy     (busy),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_c0   (add_c0),
        .add_s    (add_s),
        .add_c    (add_c)
    );

    // The shared ripple-carry adder, modelled behaviourally.
    assign {add_c, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_c0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_opnd(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic c);
        a_in[i*WIDTH +: WIDTH] = a;
        b_in[i*WIDTH +: WIDTH] = b;
        cin[i]                 = c;
    endtask

    task automatic wait_gnt(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == '0 && n < 20);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done == '0 && n < 20);
    endtask

    // One complete operation: present req, check the grant, then check the completion and result.
    task automatic op(input string tag, input logic [N_REQ-1:0] r, input int exp_idx,
                      input logic [WIDTH-1:0] exp_sum, input logic exp_c,
                      input bit drop, input bit chk_space);
        int n;
        logic [N_REQ-1:0] exp_oh;
        exp_oh = 4'b0001 << exp_idx;
        req = r;
        wait_gnt(n);
        check({tag, "_gnt"}, gnt, exp_oh);
        if (chk_space) check({tag, "_spacing"}, cyc - last_gnt_cyc, SETTLE + 2);
        last_gnt_cyc = cyc;
        wait_done(n);
        check({tag, "_done"}, done, exp_oh);
        check({tag, "_latency"}, n, SETTLE);
        check({tag, "_sum"}, sum_out, exp_sum);
        check({tag, "_cout"}, cout_out, exp_c);
        check({tag, "_gnt_low"}, gnt, 0);
        if (drop) req = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int n;
        bit saw_done;
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        last_gnt_cyc = 0;
        req          = '0;
        a_in         = '0;
        b_in         = '0;
        cin          = '0;
        rst_n        = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_sum", sum_out, 0);
        check("rst_adda", add_a, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // 5 + 7 + 0 on requester 0: busy and operands presented on the grant cycle.
        set_opnd(0, 64'd5, 64'd7, 1'b0);
        req = 4'b0001;
        wait_gnt(n);
        check("t1_gnt", gnt, 4'b0001);
        check("t1_gnt_lat", n, 1);
        check("t1_busy", busy, 1);
        check("t1_add_a", add_a, 64'd5);
        check("t1_add_b", add_b, 64'd7);
        wait_done(n);
        check("t1_done", done, 4'b0001);
        check("t1_lat", n, SETTLE);
        check("t1_sum", sum_out, 64'd12);
        check("t1_cout", cout_out, 0);
        req = '0;
        @(negedge clk);
        check("t1_done_pulse", done, 0);
        check("t1_idle", busy, 0);
        check("t1_sum_hold", sum_out, 64'd12);

        // Full carry ripple: all-ones + 0 + 1.
        set_opnd(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1);
        op("t2", 4'b0001, 0, 64'd0, 1'b1, 1'b1, 1'b0);

        // All requesters held: order 0,1,2,3,0, spacing SETTLE+2.
        do_reset();
        set_opnd(0, 64'd1,   64'd0,  1'b0);   // 1
        set_opnd(1, 64'd101, 64'd10, 1'b1);   // 112
        set_opnd(2, 64'd201, 64'd20, 1'b0);   // 221
        set_opnd(3, 64'd301, 64'd30, 1'b1);   // 332
        op("t3_r0", 4'b1111, 0, 64'd1,   1'b0, 1'b0, 1'b0);
        op("t3_r1", 4'b1111, 1, 64'd112, 1'b0, 1'b0, 1'b1);
        op("t3_r2", 4'b1111, 2, 64'd221, 1'b0, 1'b0, 1'b1);
        op("t3_r3", 4'b1111, 3, 64'd332, 1'b0, 1'b0, 1'b1);
        op("t3_r0b", 4'b1111, 0, 64'd1,  1'b0, 1'b1, 1'b1);

        // Priority after ptr=2, then the 3 -> 0 wrap.
        do_reset();
        op("t4_p2", 4'b0010, 1, 64'd112, 1'b0, 1'b1, 1'b0);
        op("t4_a",  4'b0011, 0, 64'd1,   1'b0, 1'b0, 1'b0);
        op("t4_b",  4'b0011, 1, 64'd112, 1'b0, 1'b1, 1'b0);
        op("t4_r3", 4'b1000, 3, 64'd332, 1'b0, 1'b1, 1'b0);
        op("t4_wrap", 4'b1001, 0, 64'd1, 1'b0, 1'b1, 1'b0);

        // Drop req and change operands after the grant.
        set_opnd(2, 64'd10, 64'd20, 1'b0);
        req = 4'b0100;
        wait_gnt(n);
        check("t5_gnt", gnt, 4'b0100);
        req = '0;
        set_opnd(2, 64'd999, 64'd1, 1'b1);
        wait_done(n);
        check("t5_done", done, 4'b0100);
        check("t5_sum", sum_out, 64'd30);
        check("t5_cout", cout_out, 0);
        check("t5_add_a_hold", add_a, 64'd10);

        // Reset in the middle of an operation (ptr is 3 here).
        @(negedge clk);
        req = 4'b1111;
        wait_gnt(n);
        check("t6_gnt", gnt, 4'b1000);
        req = '0;
        #2 rst_n = 1'b0;
        #1;
        check("t6_gnt_rst", gnt, 0);
        check("t6_done_rst", done, 0);
        check("t6_busy_rst", busy, 0);
        check("t6_sum_rst", sum_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (done != '0 || busy) saw_done = 1'b1;
        end
        check("t6_no_done", saw_done, 0);
        op("t6_ptr0", 4'b1111, 0, 64'd1, 1'b0, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
